// File: rtl/fifo_pkg.sv
// Types shared by the single-clock and dual-clock FIFOs.
package fifo_pkg;

    typedef enum logic {
        MODE_STD,
        MODE_FWFT
    } fifo_mode_e;

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port RAM: one write port, one registered read port, no reset so it maps to block RAM.
module sync_fifo_mem #(
    parameter int DATA_LEN   = 16,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_LEN-1:0]   wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_LEN-1:0]   rd_data
);

    logic [DATA_LEN-1:0] mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with standard or first-word-fall-through read mode, fill level,
// almost-full/empty thresholds, sticky error flags and flush.
module sync_fifo import fifo_pkg::*; #(
    parameter int         DATA_LEN   = 16,
    parameter int         FIFO_DEPTH = 512,
    parameter int         PNTR_WIDTH = $clog2(FIFO_DEPTH),
    parameter fifo_mode_e MODE       = MODE_STD,
    parameter int         AF_THRESH  = FIFO_DEPTH - 4,
    parameter int         AE_THRESH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  clear_err,
    input  logic                  write_en,
    input  logic [DATA_LEN-1:0]   data_in,
    input  logic                  read_en,
    output logic [DATA_LEN-1:0]   data_out,
    output logic                  data_valid,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [PNTR_WIDTH:0]   fill_level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [PNTR_WIDTH:0] DEPTH_L = (PNTR_WIDTH + 1)'(FIFO_DEPTH);
    localparam logic [PNTR_WIDTH:0] AF_L    = (PNTR_WIDTH + 1)'(AF_THRESH);
    localparam logic [PNTR_WIDTH:0] AE_L    = (PNTR_WIDTH + 1)'(AE_THRESH);

    logic [PNTR_WIDTH-1:0] wr_ptr;
    logic [PNTR_WIDTH-1:0] rd_ptr;
    logic [PNTR_WIDTH:0]   fill_q;
    logic                  hold;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ovf_set;
    logic                  unf_set;
    logic                  mem_rd_en;
    logic [DATA_LEN-1:0]   mem_rd_data;
    logic                  valid_q;

    assign hold         = reset || flush;
    assign fill_level   = fill_q;
    assign fifo_full    = (fill_q == DEPTH_L);
    assign fifo_empty   = (fill_q == '0);
    assign almost_full  = (fill_q >= AF_L);
    assign almost_empty = (fill_q <= AE_L);
    assign data_valid   = valid_q;

    assign wr_acc  = write_en && !fifo_full && !hold;
    assign ovf_set = write_en && fifo_full && !hold;

    sync_fifo_mem #(
        .DATA_LEN   (DATA_LEN),
        .ADDR_WIDTH (PNTR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (mem_rd_en),
        .rd_addr (rd_ptr),
        .rd_data (mem_rd_data)
    );

    // The RAM read register doubles as the FWFT output register, so it is
    // refilled whenever it is empty or its word is being popped.
    generate
        if (MODE == MODE_FWFT) begin : g_fwft
            logic [PNTR_WIDTH:0] ram_count;

            assign ram_count = fill_q - (PNTR_WIDTH + 1)'(valid_q);
            assign rd_acc    = read_en && valid_q && !hold;
            assign unf_set   = read_en && !valid_q && !hold;
            assign mem_rd_en = (ram_count != '0) && (!valid_q || rd_acc) && !hold;
            assign data_out  = valid_q ? mem_rd_data : '0;

            always_ff @(posedge clk) begin
                if (hold) begin
                    valid_q <= 1'b0;
                end else if (mem_rd_en) begin
                    valid_q <= 1'b1;
                end else if (rd_acc) begin
                    valid_q <= 1'b0;
                end
            end
        end else begin : g_std
            logic loaded_q;

            assign rd_acc    = read_en && !fifo_empty && !hold;
            assign unf_set   = read_en && fifo_empty && !hold;
            assign mem_rd_en = rd_acc;
            assign data_out  = loaded_q ? mem_rd_data : '0;

            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_q  <= 1'b0;
                    loaded_q <= 1'b0;
                end else begin
                    valid_q <= rd_acc;
                    if (rd_acc) begin
                        loaded_q <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (hold) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (mem_rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   fill_q <= fill_q + 1'b1;
                2'b01:   fill_q <= fill_q - 1'b1;
                default: fill_q <= fill_q;
            endcase
        end
    end

    // Error flags survive flush; a new error in the same cycle beats clear_err.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clear_err) begin
                overflow <= 1'b0;
            end
            if (unf_set) begin
                underflow <= 1'b1;
            end else if (clear_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench: an 8-deep standard-mode FIFO and an 8-deep FWFT FIFO driven from one linear sequence.
module tb_sync_fifo;
    import fifo_pkg::*;

    logic        clk;
    logic        reset;

    logic        s_flush, s_clear_err, s_write_en, s_read_en;
    logic [15:0] s_data_in, s_data_out;
    logic        s_data_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic [3:0]  s_fill;

    logic        f_flush, f_clear_err, f_write_en, f_read_en;
    logic [15:0] f_data_in, f_data_out;
    logic        f_data_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [3:0]  f_fill;

    int vectors;
    int miscompares;

    sync_fifo #(
        .DATA_LEN (16), .FIFO_DEPTH (8), .MODE (MODE_STD), .AF_THRESH (6), .AE_THRESH (2)
    ) u_std (
        .clk (clk), .reset (reset), .flush (s_flush), .clear_err (s_clear_err),
        .write_en (s_write_en), .data_in (s_data_in), .read_en (s_read_en),
        .data_out (s_data_out), .data_valid (s_data_valid), .fifo_full (s_full),
        .fifo_empty (s_empty), .almost_full (s_af), .almost_empty (s_ae),
        .fill_level (s_fill), .overflow (s_ovf), .underflow (s_unf)
    );

    sync_fifo #(
        .DATA_LEN (16), .FIFO_DEPTH (8), .MODE (MODE_FWFT)
    ) u_fwft (
        .clk (clk), .reset (reset), .flush (f_flush), .clear_err (f_clear_err),
        .write_en (f_write_en), .data_in (f_data_in), .read_en (f_read_en),
        .data_out (f_data_out), .data_valid (f_data_valid), .fifo_full (f_full),
        .fifo_empty (f_empty), .almost_full (f_af), .almost_empty (f_ae),
        .fill_level (f_fill), .overflow (f_ovf), .underflow (f_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        {s_flush, s_clear_err, s_write_en, s_read_en} = '0;
        {f_flush, f_clear_err, f_write_en, f_read_en} = '0;
        s_data_in = '0;
        f_data_in = '0;
        tick();
        tick();

        // Reset state of both instances
        checkOutput("rst_fill",  32'(s_fill), 32'd0);
        checkOutput("rst_empty", 32'(s_empty), 32'd1);
        checkOutput("rst_ae",    32'(s_ae), 32'd1);
        checkOutput("rst_af",    32'(s_af), 32'd0);
        checkOutput("rst_full",  32'(s_full), 32'd0);
        checkOutput("rst_valid", 32'(s_data_valid), 32'd0);
        checkOutput("rst_dout",  32'(s_data_out), 32'd0);
        checkOutput("rst_ovf",   32'(s_ovf), 32'd0);
        checkOutput("rst_unf",   32'(s_unf), 32'd0);
        checkOutput("rst_f_empty", 32'(f_empty), 32'd1);
        checkOutput("rst_f_valid", 32'(f_data_valid), 32'd0);
        checkOutput("rst_f_dout",  32'(f_data_out), 32'd0);
        reset = 1'b0;

        // Fill to full; almost_empty drops on the 3rd write, almost_full rises on the 6th
        for (int k = 1; k <= 8; k++) begin
            s_write_en = 1'b1;
            s_data_in  = 16'(k);
            tick();
            checkOutput("fill_wr", 32'(s_fill), 32'(k));
            checkOutput("ae_wr",   32'(s_ae), (k < 3) ? 32'd1 : 32'd0);
            checkOutput("af_wr",   32'(s_af), (k >= 6) ? 32'd1 : 32'd0);
        end
        checkOutput("full", 32'(s_full), 32'd1);

        s_data_in = 16'h0099;
        tick();
        checkOutput("ovf_set",   32'(s_ovf), 32'd1);
        checkOutput("ovf_fill",  32'(s_fill), 32'd8);
        s_write_en = 1'b0;

        for (int k = 1; k <= 8; k++) begin
            s_read_en = 1'b1;
            tick();
            checkOutput("rd_valid", 32'(s_data_valid), 32'd1);
            checkOutput("rd_data",  32'(s_data_out), 32'(k));
        end
        s_read_en = 1'b0;
        tick();
        checkOutput("rd_pulse_end", 32'(s_data_valid), 32'd0);
        checkOutput("rd_empty",     32'(s_empty), 32'd1);
        checkOutput("rd_hold",      32'(s_data_out), 32'd8);

        // Underflow and clear_err
        s_read_en = 1'b1;
        tick();
        checkOutput("unf_set",   32'(s_unf), 32'd1);
        checkOutput("unf_valid", 32'(s_data_valid), 32'd0);
        checkOutput("ovf_kept",  32'(s_ovf), 32'd1);
        s_read_en   = 1'b0;
        s_clear_err = 1'b1;
        tick();
        s_clear_err = 1'b0;
        checkOutput("unf_clr", 32'(s_unf), 32'd0);
        checkOutput("ovf_clr", 32'(s_ovf), 32'd0);

        // Pointer wrap with simultaneous write+read at fill level 3
        for (int k = 0; k < 3; k++) begin
            s_write_en = 1'b1;
            s_data_in  = 16'h0100 + 16'(k);
            tick();
        end
        for (int k = 0; k < 20; k++) begin
            s_write_en = 1'b1;
            s_read_en  = 1'b1;
            s_data_in  = 16'h0103 + 16'(k);
            tick();
            checkOutput("wrap_fill", 32'(s_fill), 32'd3);
            checkOutput("wrap_data", 32'(s_data_out), 32'h0100 + 32'(k));
        end
        s_read_en = 1'b0;

        // Refill to full, overflow, drain three, then flush at fill level 5
        for (int k = 0; k < 5; k++) begin
            s_data_in = 16'h0117 + 16'(k);
            tick();
        end
        s_data_in = 16'h01FF;
        tick();
        checkOutput("pre_flush_ovf", 32'(s_ovf), 32'd1);
        s_write_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s_read_en = 1'b1;
            tick();
            checkOutput("pre_flush_rd", 32'(s_data_out), 32'h0114 + 32'(k));
        end
        s_read_en = 1'b0;
        checkOutput("pre_flush_fill", 32'(s_fill), 32'd5);
        s_flush = 1'b1;
        tick();
        s_flush = 1'b0;
        checkOutput("flush_fill",  32'(s_fill), 32'd0);
        checkOutput("flush_empty", 32'(s_empty), 32'd1);
        checkOutput("flush_valid", 32'(s_data_valid), 32'd0);
        checkOutput("flush_ovf",   32'(s_ovf), 32'd1);

        s_write_en = 1'b1;
        s_data_in  = 16'h0055;
        tick();
        s_write_en = 1'b0;
        s_read_en  = 1'b1;
        tick();
        s_read_en  = 1'b0;
        checkOutput("post_flush_data", 32'(s_data_out), 32'h0055);

        // FWFT: single word fall-through, stability, pop
        f_write_en = 1'b1;
        f_data_in  = 16'hABCD;
        tick();
        f_write_en = 1'b0;
        checkOutput("fw_valid_n",  32'(f_data_valid), 32'd0);
        checkOutput("fw_fill_n",   32'(f_fill), 32'd1);
        tick();
        checkOutput("fw_valid_n1", 32'(f_data_valid), 32'd1);
        checkOutput("fw_data_n1",  32'(f_data_out), 32'hABCD);
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput("fw_stable_v", 32'(f_data_valid), 32'd1);
            checkOutput("fw_stable_d", 32'(f_data_out), 32'hABCD);
        end
        f_read_en = 1'b1;
        tick();
        f_read_en = 1'b0;
        checkOutput("fw_pop_valid", 32'(f_data_valid), 32'd0);
        checkOutput("fw_pop_fill",  32'(f_fill), 32'd0);
        checkOutput("fw_pop_unf",   32'(f_unf), 32'd0);

        f_read_en = 1'b1;
        tick();
        f_read_en = 1'b0;
        checkOutput("fw_unf", 32'(f_unf), 32'd1);

        // FWFT back-to-back pops
        for (int k = 1; k <= 3; k++) begin
            f_write_en = 1'b1;
            f_data_in  = 16'(k);
            tick();
        end
        f_write_en = 1'b0;
        tick();
        checkOutput("fw_b2b_first", 32'(f_data_out), 32'd1);
        checkOutput("fw_b2b_fill",  32'(f_fill), 32'd3);
        for (int k = 2; k <= 3; k++) begin
            f_read_en = 1'b1;
            tick();
            checkOutput("fw_b2b_valid", 32'(f_data_valid), 32'd1);
            checkOutput("fw_b2b_data",  32'(f_data_out), 32'(k));
        end
        tick();
        f_read_en = 1'b0;
        checkOutput("fw_b2b_done",  32'(f_data_valid), 32'd0);
        checkOutput("fw_b2b_empty", 32'(f_empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
